apb_master_arbiter: RTL and testbench

Shares a single APB4 master port between `NUM_REQ` on-chip requesters. It round-robin arbitrates their transfer requests and sequences the APB SETUP and ACCESS phases. It returns read data and error status to the winning requester, and aborts transfers whose slave never asserts `pready`. It drives the master side of the team's APB interface, with 12-bit address and 32-bit data.

---
 rtl/apb_arb_pkg.sv | 14 +
 rtl/apb_rr_arb.sv | 35 +++
 rtl/apb_master_arbiter.sv | 145 ++++++++++++++
 tb/tb_apb_master_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    localparam int APB_AW     = 12;
    localparam int APB_DW     = 32;
    localparam int APB_PROT_W = 3;

endpackage

// File: rtl/apb_rr_arb.sv
// Combinational round-robin grant: the first requester after last_gnt wins.
module apb_rr_arb
    import apb_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx,
    output logic               gnt_valid
);

    logic [IW-1:0] cand;

    // Scan from farthest to nearest so the requester closest after last_gnt wins.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(last_gnt) + i) % NUM_REQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB4 master port between NUM_REQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing, response return and pready timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 255
) (
    input  logic                           pclk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AW-1:0]          req_addr,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*DW-1:0]          req_wdata,
    input  logic [NUM_REQ*DW/8-1:0]        req_strb,
    input  logic [NUM_REQ*APB_PROT_W-1:0]  req_prot,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DW-1:0]                  rsp_rdata,
    output logic                           rsp_err,
    output logic [AW-1:0]                  paddr,
    output logic                           pwrite,
    output logic                           psel,
    output logic                           penable,
    output logic [DW-1:0]                  pwdata,
    output logic [DW/8-1:0]                pstrb,
    output logic [APB_PROT_W-1:0]          pprot,
    input  logic [DW-1:0]                  prdata,
    input  logic                           pready,
    input  logic                           pslverr,
    output logic                           busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    apb_arb_state_e state_q, state_d;
    logic [IW-1:0]      last_gnt_q;
    logic [CW-1:0]      cnt_q;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic               xfer_done;
    logic               xfer_tmo;
    logic               grant_en;

    apb_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .last_gnt  (last_gnt_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Completion, timeout abort, and when a new grant may be issued.
    assign xfer_done = (state_q == ACCESS) && pready;
    assign xfer_tmo  = (state_q == ACCESS) && !pready && (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign grant_en  = arb_valid && !rst && ((state_q == IDLE) || xfer_done);
    assign req_ready = grant_en ? arb_gnt : '0;
    assign busy      = psel;

    // State register and round-robin pointer.
    always_ff @(posedge pclk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= IW'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            if (grant_en) last_gnt_q <= arb_idx;
        end
    end

    // Next-state and APB phase decode.
    always_comb begin
        state_d = state_q;
        psel    = 1'b0;
        penable = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_en) state_d = SETUP;
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (xfer_done)     state_d = grant_en ? SETUP : IDLE;
                else if (xfer_tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner's fields; reads carry zero data and strobes.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
            pprot  <= '0;
        end else if (grant_en) begin
            paddr  <= req_addr[arb_idx*AW +: AW];
            pwrite <= req_write[arb_idx];
            pwdata <= req_write[arb_idx] ? req_wdata[arb_idx*DW +: DW] : '0;
            pstrb  <= req_write[arb_idx] ? req_strb[arb_idx*SW +: SW] : '0;
            pprot  <= req_prot[arb_idx*APB_PROT_W +: APB_PROT_W];
        end
    end

    // Wait-state counter: cleared on SETUP entry, saturates instead of wrapping.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (grant_en) begin
            cnt_q <= '0;
        end else if ((state_q == ACCESS) && !pready && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // One-cycle response pulse to the requester whose transfer just ended.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (xfer_done || xfer_tmo) begin
                rsp_valid <= NUM_REQ'(1) << last_gnt_q;
                rsp_err   <= xfer_tmo ? 1'b1 : pslverr;
                rsp_rdata <= (xfer_done && !pwrite) ? prdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench: a transfer-level model checks every output each cycle,
// and directed scenarios pin latency, ordering, timeout and reset behaviour.
module tb_apb_master_arbiter;
    import apb_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic                pclk = 1'b0;
    logic                rst  = 1'b1;
    logic [N-1:0]        req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0]     req_addr;
    logic [N*DW-1:0]     req_wdata;
    logic [N*SW-1:0]     req_strb;
    logic [N*3-1:0]      req_prot;
    logic [DW-1:0]       rsp_rdata, pwdata, prdata;
    logic                rsp_err, pwrite, psel, penable, pready, pslverr, busy;
    logic [AW-1:0]       paddr;
    logic [SW-1:0]       pstrb;
    logic [2:0]          pprot;

    apb_master_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .paddr(paddr), .pwrite(pwrite), .psel(psel),
        .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
    );

    initial forever #5 pclk = ~pclk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requester shadow state ----------------
    int              cnt     [N];
    logic            f_write [N];
    logic [AW-1:0]   f_addr  [N];
    logic [DW-1:0]   f_wdata [N];
    logic [SW-1:0]   f_strb  [N];
    logic [2:0]      f_prot  [N];

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic [2:0] p, input int n);
        f_write[i] = wr; f_addr[i] = a; f_wdata[i] = d; f_strb[i] = s; f_prot[i] = p;
        cnt[i] += n;
    endtask

    // Requesters: hold valid while transfers remain, retire one per accept.
    initial begin : driver
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0; f_write[i] = 0; f_addr[i] = '0; f_wdata[i] = '0; f_strb[i] = '0; f_prot[i] = '0;
        end
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
        forever begin
            @(negedge pclk);
            r = req_ready;
            @(posedge pclk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (r[i] && cnt[i] > 0) cnt[i]--;
                req_valid[i]          = (cnt[i] > 0);
                req_write[i]          = f_write[i];
                req_addr[i*AW +: AW]  = f_addr[i];
                req_wdata[i*DW +: DW] = f_wdata[i];
                req_strb[i*SW +: SW]  = f_strb[i];
                req_prot[i*3 +: 3]    = f_prot[i];
            end
        end
    end

    // ---------------- APB slave ----------------
    int           s_wait = 0;
    bit           s_hang = 0;
    bit           s_err  = 0;
    logic [DW-1:0] s_rdata = '0;

    initial begin : slave
        int acc;
        acc = 0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0;
        forever begin
            @(posedge pclk);
            #1;
            if (psel && penable) acc++; else acc = 0;
            pready  = psel && penable && !s_hang && (acc > s_wait);
            prdata  = s_rdata;
            pslverr = s_err && pready;
        end
    end

    // ---------------- model, compare and event log ----------------
    typedef struct {
        int            idx;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
    } xfer_t;

    int cyc = 0;
    int acc_cyc[$], acc_idx[$], rsp_cyc[$];
    logic [N-1:0]  rsp_vec[$];
    logic [DW-1:0] rsp_dat[$];
    logic          rsp_e[$], rsp_ps[$];
    int pen_cnt, psel_cnt, first_setup;
    logic [SW-1:0] strb_or;

    task automatic clear_log();
        acc_cyc.delete(); acc_idx.delete(); rsp_cyc.delete(); rsp_vec.delete();
        rsp_dat.delete(); rsp_e.delete(); rsp_ps.delete();
        pen_cnt = 0; psel_cnt = 0; first_setup = -1; strb_or = '0;
    endtask

    initial begin : model
        xfer_t         m_x;
        bit            m_busy, m_rv, in_acc, done, tmo;
        int            m_age, m_last, m_ridx, win, c, aidx;
        logic [DW-1:0] m_rdata;
        logic          m_rerr;
        logic [N-1:0]  exp_rdy, exp_rsp;
        m_busy = 0; m_age = 0; m_last = N - 1; m_rv = 0; m_ridx = 0; m_rdata = '0; m_rerr = 0;
        m_x = '{0, 1'b0, '0, '0, '0, '0};
        clear_log();
        forever begin
            @(negedge pclk);
            cyc++;
            if (rst) begin
                m_busy = 0; m_age = 0; m_last = N - 1; m_rv = 0;
                check("reset_ctrl", {req_ready, rsp_valid, psel, penable, busy, pwrite, paddr, pstrb, pprot, rsp_err}, '0);
                check("reset_data", {pwdata, rsp_rdata}, '0);
            end else begin
                in_acc = m_busy && (m_age >= 2);
                done   = in_acc && pready;
                tmo    = in_acc && !pready && ((m_age - 1) == TO);
                win    = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (win < 0 && req_valid[c]) win = c;
                end
                exp_rdy = '0;
                if ((!m_busy || done) && win >= 0) exp_rdy[win] = 1'b1;
                exp_rsp = '0;
                if (m_rv) exp_rsp[m_ridx] = 1'b1;

                check("req_ready", req_ready, exp_rdy);
                check("psel_penable_busy", {psel, penable, busy}, {m_busy, in_acc, m_busy});
                check("rsp_valid", rsp_valid, exp_rsp);
                if (m_busy) begin
                    check("apb_ctrl", {pwrite, paddr, pstrb, pprot},
                          {m_x.wr, m_x.addr, (m_x.wr ? m_x.strb : 4'h0), m_x.prot});
                    check("apb_pwdata", pwdata, m_x.wr ? m_x.wdata : '0);
                end
                if (m_rv) check("rsp_err_rdata", {rsp_err, rsp_rdata}, {m_rerr, m_rdata});

                // event log for the directed checks
                if (req_ready != '0) begin
                    aidx = -1;
                    for (int k = 0; k < N; k++) if (req_ready[k]) aidx = k;
                    acc_cyc.push_back(cyc); acc_idx.push_back(aidx);
                end
                if (rsp_valid != '0) begin
                    rsp_cyc.push_back(cyc); rsp_vec.push_back(rsp_valid);
                    rsp_dat.push_back(rsp_rdata); rsp_e.push_back(rsp_err); rsp_ps.push_back(psel);
                end
                if (penable) pen_cnt++;
                if (psel) begin
                    psel_cnt++;
                    strb_or = strb_or | pstrb;
                end
                if (psel && !penable && first_setup < 0) first_setup = cyc;

                // advance to the next cycle
                m_rv    = done || tmo;
                m_ridx  = m_x.idx;
                m_rdata = (done && !m_x.wr) ? prdata : '0;
                m_rerr  = tmo ? 1'b1 : pslverr;
                if ((!m_busy || done) && win >= 0) begin
                    m_x.idx   = win;
                    m_x.wr    = req_write[win];
                    m_x.addr  = req_addr[win*AW +: AW];
                    m_x.wdata = req_wdata[win*DW +: DW];
                    m_x.strb  = req_strb[win*SW +: SW];
                    m_x.prot  = req_prot[win*3 +: 3];
                    m_busy = 1; m_age = 1; m_last = win;
                end else if (done || tmo) begin
                    m_busy = 0;
                end else if (m_busy) begin
                    m_age++;
                end
            end
        end
    end

    // Wait until no requests remain, the port is idle and responses have drained.
    task automatic wait_quiet(input string name, input int budget);
        int n;
        bit pend;
        n = 0;
        forever begin
            @(negedge pclk);
            #1;
            pend = 0;
            for (int i = 0; i < N; i++) if (cnt[i] > 0) pend = 1;
            if ((!pend && req_valid == '0 && !busy && rsp_valid == '0) || n >= budget) break;
            n++;
        end
        check(name, (n < budget), 1);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied", vectors);
        $fatal(1, "time limit");
    end

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int  n;
        logic [19:0] ord;
        repeat (3) @(negedge pclk);
        #1 rst = 1'b0;
        @(negedge pclk);
        #2;

        // Single zero-wait write from requester 2.
        clear_log();
        set_req(2, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b000, 1);
        wait_quiet("t1_done", 20);
        check("t1_counts", {32'(acc_cyc.size()), 32'(rsp_cyc.size())}, {32'd1, 32'd1});
        if (acc_cyc.size() == 1 && rsp_cyc.size() == 1) begin
            check("t1_winner", acc_idx[0], 2);
            check("t1_setup_at_1", first_setup - acc_cyc[0], 1);
            check("t1_rsp_at_3", rsp_cyc[0] - acc_cyc[0], 3);
            check("t1_rsp", {rsp_vec[0], rsp_e[0], rsp_dat[0]}, {4'b0100, 1'b0, 32'h0});
        end
        check("t1_access_cycles", pen_cnt, 1);

        // Read from requester 1 with three wait states.
        clear_log();
        s_wait = 3; s_rdata = 32'h12345678;
        set_req(1, 1'b0, 12'h024, 32'hCAFEF00D, 4'hF, 3'b010, 1);
        wait_quiet("t2_done", 30);
        check("t2_access_cycles", pen_cnt, 4);
        check("t2_pstrb_zero", strb_or, 0);
        if (acc_cyc.size() == 1 && rsp_cyc.size() == 1) begin
            check("t2_rsp_latency", rsp_cyc[0] - acc_cyc[0], 6);
            check("t2_rsp", {rsp_vec[0], rsp_e[0], rsp_dat[0]}, {4'b0010, 1'b0, 32'h12345678});
        end else begin
            check("t2_counts", {32'(acc_cyc.size()), 32'(rsp_cyc.size())}, {32'd1, 32'd1});
        end

        // All requesters continuously valid from reset, two transfers each.
        @(negedge pclk);
        #1 rst = 1'b1;
        repeat (2) @(negedge pclk);
        #1 rst = 1'b0;
        @(negedge pclk);
        #2;
        clear_log();
        s_wait = 0; s_rdata = 32'hA5A50000;
        for (int i = 0; i < N; i++)
            set_req(i, (i % 2 == 0), 12'h100 + 12'(i * 4), 32'h11110000 + 32'(i), 4'h3 << i[1:0], 3'(i), 2);
        wait_quiet("t3_done", 60);
        check("t3_counts", {32'(acc_cyc.size()), 32'(rsp_cyc.size())}, {32'd8, 32'd8});
        if (acc_cyc.size() == 8) begin
            ord = '0;
            for (int k = 0; k < 5; k++) ord = (ord << 4) | 20'(acc_idx[k]);
            check("t3_grant_order", ord, 20'h01230);
            check("t3_two_cycles_per_xfer", acc_cyc[7] - acc_cyc[0], 14);
        end
        check("t3_psel_continuous", psel_cnt, 16);

        // Slave error on a write from requester 3.
        clear_log();
        s_err = 1;
        set_req(3, 1'b1, 12'h3FC, 32'h0000BEEF, 4'h5, 3'b111, 1);
        wait_quiet("t4_done", 20);
        s_err = 0;
        if (rsp_cyc.size() == 1) check("t4_rsp", {rsp_vec[0], rsp_e[0]}, {4'b1000, 1'b1});
        else check("t4_rsp_count", rsp_cyc.size(), 1);

        // Slave never ready: two requests, both time out, no back-to-back grant.
        clear_log();
        s_hang = 1;
        set_req(0, 1'b0, 12'h040, 32'h0, 4'hF, 3'b000, 1);
        set_req(1, 1'b0, 12'h044, 32'h0, 4'hF, 3'b000, 1);
        wait_quiet("t5_done", 60);
        s_hang = 0;
        check("t5_access_cycles", pen_cnt, 16);
        if (acc_cyc.size() == 2 && rsp_cyc.size() == 2) begin
            check("t5_first_winner", acc_idx[0], 0);
            check("t5_abort_latency", rsp_cyc[0] - acc_cyc[0], 10);
            check("t5_regrant_from_idle", acc_cyc[1] - acc_cyc[0], 10);
            check("t5_rsp", {rsp_vec[0], rsp_e[0], rsp_dat[0], rsp_ps[0]}, {4'b0001, 1'b1, 32'h0, 1'b0});
        end else begin
            check("t5_counts", {32'(acc_cyc.size()), 32'(rsp_cyc.size())}, {32'd2, 32'd2});
        end

        // Reset pulsed during ACCESS, then all four request again.
        s_wait = 5;
        set_req(1, 1'b1, 12'h0F0, 32'h0BADF00D, 4'h3, 3'b001, 1);
        n = 0;
        forever begin
            @(negedge pclk);
            #1;
            if (penable || n >= 20) break;
            n++;
        end
        check("t6_reach_access", penable, 1);
        clear_log();
        rst = 1'b1;
        #1;
        check("t6_async_drop", {psel, penable, busy}, 3'b000);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        repeat (2) @(negedge pclk);
        #1 rst = 1'b0;
        @(negedge pclk);
        #2;
        s_wait = 0;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 12'h200 + 12'(i * 4), 32'h0, 4'hF, 3'b000, 1);
        wait_quiet("t6_done", 40);
        check("t6_rsp_count_no_stale", rsp_cyc.size(), 4);
        if (acc_idx.size() > 0 && rsp_vec.size() > 0) begin
            check("t6_first_winner", acc_idx[0], 0);
            check("t6_first_rsp", rsp_vec[0], 4'b0001);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
